// File: rtl/pit_pkg.sv
// Shared types and helpers for the PIT prescale sequencing logic.
package pit_pkg;

  localparam int unsigned PIT_DIV_W = 4;

  // Largest legal divisor code in decade encoding.
  localparam logic [PIT_DIV_W-1:0] PIT_DEC_MAX_DIV = PIT_DIV_W'(8);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SWITCH = 2'd2,
    HALT   = 2'd3
  } pit_psc_state_e;

  // Clamp a written divisor code to the legal range of the active encoding.
  function automatic logic [PIT_DIV_W-1:0] pit_clamp_div(
    input logic [PIT_DIV_W-1:0] code,
    input logic                 decade
  );
    logic [PIT_DIV_W-1:0] res;
    res = code;
    if (decade && (code > PIT_DEC_MAX_DIV)) res = PIT_DEC_MAX_DIV;
    return res;
  endfunction

endpackage

// File: rtl/pit_div_shadow.sv
// Shadow divisor register with pending flag; holds a divisor written while
// the prescaler runs until the controller applies it at a rollover.
module pit_div_shadow
  import pit_pkg::*;
#(
  parameter bit DECADE_CNTR = 1'b1
) (
  input  logic                 bus_clk,
  input  logic                 async_rst_b,
  input  logic                 sync_reset,
  input  logic                 load,
  input  logic                 apply,
  input  logic [PIT_DIV_W-1:0] wdata,
  output logic                 pending,
  output logic [PIT_DIV_W-1:0] wdata_clamped_c,
  output logic [PIT_DIV_W-1:0] apply_data_c
);

  logic [PIT_DIV_W-1:0] shadow;

  assign wdata_clamped_c = pit_clamp_div(wdata, DECADE_CNTR);
  // A write landing on the applying tick wins over the stored shadow.
  assign apply_data_c    = load ? wdata_clamped_c : shadow;

  // Shadow value and pending flag; apply always consumes the pending request.
  always_ff @(posedge bus_clk or negedge async_rst_b) begin
    if (!async_rst_b) begin
      shadow  <= '0;
      pending <= 1'b0;
    end else if (sync_reset) begin
      shadow  <= '0;
      pending <= 1'b0;
    end else begin
      if (load) shadow <= wdata_clamped_c;
      if (apply)     pending <= 1'b0;
      else if (load) pending <= 1'b1;
    end
  end

endmodule

// File: rtl/pit_psc_ctrl.sv
// PIT prescale sequencing controller: FSM, divisor hand-off and tick counter.
// Optional burst mode is built when PIT_PSC_BURST_EN is defined.
module pit_psc_ctrl
  import pit_pkg::*;
#(
  parameter int unsigned DECADE_CNTR = 1,
  parameter int unsigned TICK_W      = 16,
  parameter int unsigned BURST_W     = 8
) (
  input  logic                 bus_clk,
  input  logic                 async_rst_b,
  input  logic                 sync_reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 div_wr,
  input  logic [PIT_DIV_W-1:0] div_wdata,
  input  logic                 prescale_out,
  input  logic [BURST_W-1:0]   burst_len,
  output logic                 cnt_sync_o,
  output logic [PIT_DIV_W-1:0] divisor,
  output logic                 div_pending,
  output logic                 busy,
  output logic [TICK_W-1:0]    tick_count,
  output logic                 burst_done
);

  pit_psc_state_e       state, state_nxt;
  logic                 tick_c;
  logic                 load_c;
  logic                 apply_c;
  logic                 idle_wr_c;
  logic                 start_c;
  logic                 burst_end_c;
  logic [PIT_DIV_W-1:0] wdata_clamped_c;
  logic [PIT_DIV_W-1:0] apply_data_c;

  // Prescale_out is only meaningful while the prescaler is enabled.
  assign tick_c = prescale_out & cnt_sync_o;

  pit_div_shadow #(
    .DECADE_CNTR (DECADE_CNTR != 0)
  ) u_shadow (
    .bus_clk         (bus_clk),
    .async_rst_b     (async_rst_b),
    .sync_reset      (sync_reset),
    .load            (load_c),
    .apply           (apply_c),
    .wdata           (div_wdata),
    .pending         (div_pending),
    .wdata_clamped_c (wdata_clamped_c),
    .apply_data_c    (apply_data_c)
  );

  // Next-state and divisor routing decisions.
  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    apply_c   = 1'b0;
    idle_wr_c = 1'b0;
    start_c   = 1'b0;
    unique case (state)
      IDLE: begin
        idle_wr_c = div_wr;
        if (start && !stop) begin
          state_nxt = RUN;
          start_c   = 1'b1;
        end
      end
      RUN: begin
        load_c = div_wr;
        if (burst_end_c) begin
          state_nxt = IDLE;
          apply_c   = div_pending || div_wr;
        end else begin
          apply_c = tick_c && div_pending;
          if (stop)         state_nxt = HALT;
          else if (apply_c) state_nxt = SWITCH;
        end
      end
      SWITCH: begin
        load_c    = div_wr;
        state_nxt = RUN;
      end
      HALT: begin
        load_c = div_wr;
        if (tick_c) begin
          state_nxt = IDLE;
          apply_c   = div_pending || div_wr;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, registered outputs and tick counter.
  always_ff @(posedge bus_clk or negedge async_rst_b) begin
    if (!async_rst_b) begin
      state      <= IDLE;
      cnt_sync_o <= 1'b0;
      busy       <= 1'b0;
      divisor    <= '0;
      tick_count <= '0;
    end else if (sync_reset) begin
      state      <= IDLE;
      cnt_sync_o <= 1'b0;
      busy       <= 1'b0;
      divisor    <= '0;
      tick_count <= '0;
    end else begin
      state      <= state_nxt;
      cnt_sync_o <= (state_nxt == RUN) || (state_nxt == HALT);
      busy       <= (state_nxt != IDLE);
      if (apply_c)        divisor <= apply_data_c;
      else if (idle_wr_c) divisor <= wdata_clamped_c;
      if (start_c) tick_count <= '0;
      else if (tick_c && ((state == RUN) || (state == HALT)))
        tick_count <= tick_count + TICK_W'(1);
    end
  end

`ifdef PIT_PSC_BURST_EN
  logic [BURST_W-1:0] burst_len_q;
  logic [BURST_W-1:0] burst_cnt;

  assign burst_end_c = (state == RUN) && tick_c && (burst_len_q != '0) &&
                       (burst_cnt == (burst_len_q - BURST_W'(1)));

  // Burst length latch, tick-in-burst counter and end-of-burst pulse.
  always_ff @(posedge bus_clk or negedge async_rst_b) begin
    if (!async_rst_b) begin
      burst_len_q <= '0;
      burst_cnt   <= '0;
      burst_done  <= 1'b0;
    end else if (sync_reset) begin
      burst_len_q <= '0;
      burst_cnt   <= '0;
      burst_done  <= 1'b0;
    end else begin
      burst_done <= burst_end_c;
      if (start_c) begin
        burst_len_q <= burst_len;
        burst_cnt   <= '0;
      end else if (tick_c && (state == RUN)) begin
        burst_cnt <= burst_cnt + BURST_W'(1);
      end
    end
  end
`else
  logic unused_burst_len;

  // Burst mode absent: length ignored, never ends a run on its own.
  assign unused_burst_len = ^burst_len;
  assign burst_end_c      = 1'b0;
  assign burst_done       = 1'b0;
`endif

endmodule

// File: tb/tb_pit_psc_ctrl.sv
// Self-checking bench for pit_psc_ctrl with a behavioural prescaler model.
module tb_pit_psc_ctrl;

  localparam int S_CNT  = 0;
  localparam int S_DIV  = 1;
  localparam int S_PEND = 2;
  localparam int S_BUSY = 3;
  localparam int S_TICK = 4;
  localparam int S_BDON = 5;
  localparam int S_BDIV = 6;
  localparam int S_IVL  = 7;

`ifdef PIT_PSC_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic        bus_clk = 1'b0;
  logic        async_rst_b, sync_reset, start, stop, div_wr;
  logic [3:0]  div_wdata;
  logic        prescale_out;
  logic [7:0]  burst_len;
  logic        cnt_sync_o, div_pending, busy, burst_done;
  logic [3:0]  divisor;
  logic [15:0] tick_count;

  logic        bin_cnt_sync_unused, bin_pending_unused, bin_busy_unused, bin_bdone_unused;
  logic [15:0] bin_tick_unused;
  logic [3:0]  bin_divisor;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   tick_log[$];
  int   cyc = 0;
  int   psc_cnt = 1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 bus_clk = ~bus_clk;

  pit_psc_ctrl #(.DECADE_CNTR(1), .TICK_W(16), .BURST_W(8)) u_dut (
    .bus_clk(bus_clk), .async_rst_b(async_rst_b), .sync_reset(sync_reset),
    .start(start), .stop(stop), .div_wr(div_wr), .div_wdata(div_wdata),
    .prescale_out(prescale_out), .burst_len(burst_len),
    .cnt_sync_o(cnt_sync_o), .divisor(divisor), .div_pending(div_pending),
    .busy(busy), .tick_count(tick_count), .burst_done(burst_done)
  );

  pit_psc_ctrl #(.DECADE_CNTR(0), .TICK_W(16), .BURST_W(8)) u_bin (
    .bus_clk(bus_clk), .async_rst_b(async_rst_b), .sync_reset(sync_reset),
    .start(start), .stop(stop), .div_wr(div_wr), .div_wdata(div_wdata),
    .prescale_out(prescale_out), .burst_len(burst_len),
    .cnt_sync_o(bin_cnt_sync_unused), .divisor(bin_divisor), .div_pending(bin_pending_unused),
    .busy(bin_busy_unused), .tick_count(bin_tick_unused), .burst_done(bin_bdone_unused)
  );

  // Prescaler end count chosen per divisor code for this environment.
  function automatic int e_of(input logic [3:0] code);
    case (code)
      4'd0:    return 1;
      4'd1:    return 2;
      4'd2:    return 100;
      4'd3:    return 8;
      4'd4:    return 10;
      4'd5:    return 16;
      default: return 4;
    endcase
  endfunction

  // Prescaler: reloads to 1 while disabled, rolls over at the end count.
  always @(posedge bus_clk) begin
    if (!cnt_sync_o || psc_cnt >= e_of(divisor)) psc_cnt <= 1;
    else psc_cnt <= psc_cnt + 1;
  end
  assign prescale_out = (psc_cnt == e_of(divisor));

  // Log the cycle of every qualified tick.
  always @(posedge bus_clk) begin
    if (cnt_sync_o && prescale_out) tick_log.push_back(cyc);
    cyc <= cyc + 1;
  end

  function automatic logic [31:0] sample(input int sel);
    case (sel)
      S_CNT:   return 32'(cnt_sync_o);
      S_DIV:   return 32'(divisor);
      S_PEND:  return 32'(div_pending);
      S_BUSY:  return 32'(busy);
      S_TICK:  return 32'(tick_count);
      S_BDON:  return 32'(burst_done);
      S_BDIV:  return 32'(bin_divisor);
      S_IVL:   return (tick_log.size() >= 2) ?
                      32'(tick_log[tick_log.size()-1] - tick_log[tick_log.size()-2]) : 32'hFFFF_FFFF;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic push(input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.tag, sample(e.sel), e.val);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge bus_clk);
    #1;
  endtask

  task automatic push_zero(input string tag);
    push({tag, "_cnt"},  S_CNT,  0);
    push({tag, "_div"},  S_DIV,  0);
    push({tag, "_pend"}, S_PEND, 0);
    push({tag, "_busy"}, S_BUSY, 0);
    push({tag, "_tick"}, S_TICK, 0);
    push({tag, "_bdon"}, S_BDON, 0);
  endtask

  task automatic idle_write(input logic [3:0] code);
    div_wr = 1'b1; div_wdata = code;
    step(1);
    div_wr = 1'b0;
  endtask

  initial begin
    async_rst_b = 1'b0; sync_reset = 1'b0; start = 1'b0; stop = 1'b0;
    div_wr = 1'b0; div_wdata = '0; burst_len = '0;
    step(2);
    push_zero("rst");
    drain();
    async_rst_b = 1'b1;
    step(1);

    // Clamp behaviour in both encodings.
    idle_write(4'd12);
    push("clamp_dec", S_DIV, 8);
    push("clamp_bin", S_BDIV, 12);
    push("clamp_pend", S_PEND, 0);
    drain();

    // IDLE write, start, ticks every 8 cycles.
    idle_write(4'd3);
    push("idle_wr_div", S_DIV, 3);
    push("idle_wr_pend", S_PEND, 0);
    drain();
    start = 1'b1;
    step(1);
    start = 1'b0;
    push("start_busy", S_BUSY, 1);
    push("start_cnt", S_CNT, 1);
    push("start_tick", S_TICK, 0);
    drain();
    step(32);
    push("run32_tick", S_TICK, 4);
    push("run32_ivl", S_IVL, 8);
    drain();

    // Shadow write in RUN, last write wins, one-cycle SWITCH.
    div_wr = 1'b1; div_wdata = 4'd5;
    step(1);
    push("sh1_pend", S_PEND, 1);
    push("sh1_div", S_DIV, 3);
    drain();
    div_wdata = 4'd4;
    step(1);
    div_wr = 1'b0;
    push("sh2_pend", S_PEND, 1);
    drain();
    step(5);
    push("pre_sw_div", S_DIV, 3);
    push("pre_sw_cnt", S_CNT, 1);
    drain();
    step(1);
    push("sw_div", S_DIV, 4);
    push("sw_cnt", S_CNT, 0);
    push("sw_pend", S_PEND, 0);
    push("sw_busy", S_BUSY, 1);
    push("sw_tick", S_TICK, 5);
    drain();
    step(1);
    push("post_sw_cnt", S_CNT, 1);
    drain();
    step(20);
    push("new_div_tick", S_TICK, 7);
    push("new_div_ivl", S_IVL, 10);
    drain();

    // Graceful stop mid-period at E=100.
    idle_write(4'd2);
    push("e100_pend", S_PEND, 1);
    drain();
    step(9);
    push("e100_div", S_DIV, 2);
    push("e100_cnt", S_CNT, 0);
    push("e100_tick", S_TICK, 8);
    drain();
    step(29);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    push("halt_busy", S_BUSY, 1);
    push("halt_cnt", S_CNT, 1);
    drain();
    step(70);
    push("halt_wait_busy", S_BUSY, 1);
    push("halt_wait_tick", S_TICK, 8);
    drain();
    step(1);
    push("stop_busy", S_BUSY, 0);
    push("stop_cnt", S_CNT, 0);
    push("stop_tick", S_TICK, 9);
    drain();
    idle_write(4'd0);
    push("code0_div", S_DIV, 0);
    drain();
    step(5);
    push("code0_idle_tick", S_TICK, 9);
    push("code0_idle_busy", S_BUSY, 0);
    drain();

    // start+stop together in RUN enters HALT; E=1 ends it on the next tick.
    start = 1'b1;
    step(1);
    start = 1'b0;
    push("e1_busy", S_BUSY, 1);
    drain();
    start = 1'b1; stop = 1'b1;
    step(1);
    start = 1'b0; stop = 1'b0;
    push("ss_busy", S_BUSY, 1);
    push("ss_tick", S_TICK, 1);
    drain();
    step(1);
    push("ss_end_busy", S_BUSY, 0);
    push("ss_end_cnt", S_CNT, 0);
    push("ss_end_tick", S_TICK, 2);
    drain();

    // Asynchronous reset mid-RUN clears outputs without a clock edge.
    idle_write(4'd3);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(10);
    push("pre_arst_busy", S_BUSY, 1);
    push("pre_arst_tick", S_TICK, 1);
    drain();
    #2 async_rst_b = 1'b0;
    #1;
    push_zero("arst");
    drain();
    async_rst_b = 1'b1;
    step(1);

    // Synchronous reset mid-RUN.
    idle_write(4'd3);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(9);
    push("pre_srst_tick", S_TICK, 1);
    drain();
    sync_reset = 1'b1;
    step(1);
    sync_reset = 1'b0;
    push_zero("srst");
    drain();

    // Burst of 3 ticks at E=2 (free-run when burst mode is absent).
    idle_write(4'd1);
    burst_len = 8'd3; start = 1'b1;
    step(1);
    start = 1'b0; burst_len = 8'd0;
    step(5);
    push("bst5_done", S_BDON, 0);
    push("bst5_busy", S_BUSY, 1);
    push("bst5_tick", S_TICK, 2);
    drain();
    step(1);
    push("bst6_done", S_BDON, BURST ? 1 : 0);
    push("bst6_busy", S_BUSY, BURST ? 0 : 1);
    push("bst6_tick", S_TICK, 3);
    drain();
    step(1);
    push("bst7_done", S_BDON, 0);
    push("bst7_busy", S_BUSY, BURST ? 0 : 1);
    push("bst7_tick", S_TICK, 3);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
